// File: rtl/token_rr_merge_pkg.sv
// Shared helpers for the token round-robin merge: source-index width sizing.
package token_rr_merge_pkg;

  function automatic int src_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/token_rr_merge_rr_pick.sv
// Rotate-priority encoder: first asserted request at or after ptr, wrapping mod N.
module rr_pick
  import token_rr_merge_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = src_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          any,
  output logic [SW-1:0] grant
);

  assign any = |req;

  // Scan offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    grant = '0;
    for (int unsigned k = N; k > 0; k--) begin
      idx = 32'(ptr) + k - 1;
      if (idx >= N) idx = idx - N;
      if (req[idx]) grant = SW'(idx);
    end
  end

endmodule

// File: rtl/token_rr_merge.sv
// Round-robin merge of NUM_IN token streams with per-source saturating transfer counters.
module token_rr_merge
  import token_rr_merge_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int CNT_WIDTH = 16,
  parameter int SRC_W     = src_width(NUM_IN)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_IN-1:0]    IN_EMPTY_N,
  output logic [NUM_IN-1:0]    IN_DEQ,
  input  logic                 OUT_FULL_N,
  output logic                 OUT_ENQ,
  output logic [SRC_W-1:0]     OUT_SRC,
  input  logic                 CLR,
  input  logic [SRC_W-1:0]     CNT_SEL,
  output logic [CNT_WIDTH-1:0] CNT_VALUE
);

  logic [SRC_W-1:0]     r_ptr;
  logic [CNT_WIDTH-1:0] r_cnt [NUM_IN];
  logic [CNT_WIDTH-1:0] r_cnt_value;
  logic                 w_any;
  logic [SRC_W-1:0]     w_grant;
  logic                 w_xfer;

  rr_pick #(
    .N  (NUM_IN),
    .SW (SRC_W)
  ) u_pick (
    .req   (IN_EMPTY_N),
    .ptr   (r_ptr),
    .any   (w_any),
    .grant (w_grant)
  );

  assign w_xfer = RST && !CLR && OUT_FULL_N && w_any;

  always_comb begin
    IN_DEQ  = '0;
    OUT_ENQ = 1'b0;
    OUT_SRC = '0;
    if (w_xfer) begin
      IN_DEQ  = NUM_IN'(1) << w_grant;
      OUT_ENQ = 1'b1;
      OUT_SRC = w_grant;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST || CLR) begin
      r_ptr <= '0;
      for (int unsigned i = 0; i < NUM_IN; i++) r_cnt[i] <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_grant == SRC_W'(NUM_IN - 1)) ? '0 : w_grant + 1'b1;
      if (r_cnt[w_grant] != '1) r_cnt[w_grant] <= r_cnt[w_grant] + 1'b1;
    end
  end

  // Read mux samples the pre-update counter; CLR does not blank the read.
  always_ff @(posedge CLK) begin
    if (!RST)
      r_cnt_value <= '0;
    else if (32'(CNT_SEL) < NUM_IN)
      r_cnt_value <= r_cnt[CNT_SEL];
    else
      r_cnt_value <= '0;
  end

  assign CNT_VALUE = r_cnt_value;

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (RST) begin
      assert ((IN_DEQ & ~IN_EMPTY_N) == '0) else $error("dequeue from empty input");
      assert (!(OUT_ENQ && !OUT_FULL_N)) else $error("enqueue into full output");
      assert ($onehot0(IN_DEQ)) else $error("dequeue not one-hot");
    end
  end
`endif

endmodule

// File: tb/tb_token_rr_merge.sv
// Directed bench: 4-input/16-bit instance plus a 3-input/2-bit instance for wrap and saturation.
module tb_token_rr_merge;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Instance A: NUM_IN=4, CNT_WIDTH=16
  logic        a_rst, a_full_n, a_clr;
  logic [3:0]  a_empty_n, a_deq;
  logic        a_enq;
  logic [1:0]  a_src, a_sel;
  logic [15:0] a_cnt;

  token_rr_merge #(.NUM_IN(4), .CNT_WIDTH(16)) dut_a (
    .CLK(CLK), .RST(a_rst), .IN_EMPTY_N(a_empty_n), .IN_DEQ(a_deq),
    .OUT_FULL_N(a_full_n), .OUT_ENQ(a_enq), .OUT_SRC(a_src),
    .CLR(a_clr), .CNT_SEL(a_sel), .CNT_VALUE(a_cnt)
  );

  // Instance B: NUM_IN=3, CNT_WIDTH=2
  logic        b_rst, b_full_n, b_clr;
  logic [2:0]  b_empty_n, b_deq;
  logic        b_enq;
  logic [1:0]  b_src, b_sel;
  logic [1:0]  b_cnt;

  token_rr_merge #(.NUM_IN(3), .CNT_WIDTH(2)) dut_b (
    .CLK(CLK), .RST(b_rst), .IN_EMPTY_N(b_empty_n), .IN_DEQ(b_deq),
    .OUT_FULL_N(b_full_n), .OUT_ENQ(b_enq), .OUT_SRC(b_src),
    .CLR(b_clr), .CNT_SEL(b_sel), .CNT_VALUE(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv;
    @(posedge CLK);
    #1;
  endtask

  task automatic smp;
    @(negedge CLK);
  endtask

  task automatic chk_a_grant(input string tag, input int g);
    chk({tag, "_enq"}, 32'(a_enq), 32'd1);
    chk({tag, "_src"}, 32'(a_src), 32'(g));
    chk({tag, "_deq"}, 32'(a_deq), 32'd1 << g);
  endtask

  task automatic chk_a_idle(input string tag);
    chk({tag, "_enq"}, 32'(a_enq), 32'd0);
    chk({tag, "_deq"}, 32'(a_deq), 32'd0);
    chk({tag, "_src"}, 32'(a_src), 32'd0);
  endtask

  task automatic chk_b_grant(input string tag, input int g);
    chk({tag, "_enq"}, 32'(b_enq), 32'd1);
    chk({tag, "_src"}, 32'(b_src), 32'(g));
    chk({tag, "_deq"}, 32'(b_deq), 32'd1 << g);
  endtask

  int exp_a [4];

  initial begin
    a_rst = 1'b0; a_clr = 1'b0; a_full_n = 1'b1; a_empty_n = 4'b1111; a_sel = '0;
    b_rst = 1'b0; b_clr = 1'b0; b_full_n = 1'b1; b_empty_n = 3'b111;  b_sel = '0;

    // Reset: outputs held low even with requests present
    smp;
    chk_a_idle("rst_hold_a");
    chk("rst_hold_b_enq", 32'(b_enq), 32'd0);
    adv; adv;
    a_rst = 1'b1; b_rst = 1'b1;
    a_empty_n = 4'b0000; b_empty_n = 3'b000;
    smp;
    chk_a_idle("idle_a");
    for (int i = 0; i < 4; i++) begin
      a_sel = 2'(i);
      adv;
      chk($sformatf("idle_cnt%0d", i), 32'(a_cnt), 32'd0);
    end

    // All busy: strict rotation 0..3 twice
    a_empty_n = 4'b1111; a_full_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      smp;
      chk_a_grant($sformatf("busy%0d", k), k % 4);
      adv;
    end
    a_empty_n = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      a_sel = 2'(i);
      adv;
      chk($sformatf("busy_cnt%0d", i), 32'(a_cnt), 32'd2);
    end

    // Clear, then sparse requests 1010 from ptr=0
    a_clr = 1'b1; a_empty_n = 4'b1111;
    smp;
    chk_a_idle("clr1");
    adv;
    a_clr = 1'b0; a_empty_n = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      smp;
      chk_a_grant($sformatf("sparse%0d", k), (k % 2 == 0) ? 1 : 3);
      adv;
    end
    a_empty_n = 4'b0000;
    exp_a[0] = 0; exp_a[1] = 2; exp_a[2] = 0; exp_a[3] = 2;
    for (int i = 0; i < 4; i++) begin
      a_sel = 2'(i);
      adv;
      chk($sformatf("sparse_cnt%0d", i), 32'(a_cnt), 32'(exp_a[i]));
    end

    // Move ptr to 1, then back-pressure for 3 cycles
    a_empty_n = 4'b0001;
    smp;
    chk_a_grant("bp_pre", 0);
    adv;
    a_empty_n = 4'b1111; a_full_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp;
      chk_a_idle($sformatf("bp%0d", k));
      adv;
    end
    a_full_n = 1'b1;
    smp;
    chk_a_grant("bp_release", 1);
    adv;

    // CLR collides with a would-be transfer on input 2
    a_empty_n = 4'b0100; a_clr = 1'b1;
    smp;
    chk_a_idle("clr_coll");
    adv;
    a_clr = 1'b0;
    smp;
    chk_a_grant("after_clr", 2);
    adv;
    a_empty_n = 4'b0000;
    a_sel = 2'd2;
    adv;
    chk("clr_cnt2", 32'(a_cnt), 32'd1);
    a_sel = 2'd1;
    adv;
    chk("clr_cnt1", 32'(a_cnt), 32'd0);

    // Saturation on the 2-bit instance: five transfers from input 0
    b_empty_n = 3'b001; b_full_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      smp;
      chk_b_grant($sformatf("sat%0d", k), 0);
      adv;
    end
    b_empty_n = 3'b000; b_sel = 2'd0;
    adv;
    chk("sat_cnt0", 32'(b_cnt), 32'd3);
    b_sel = 2'd3;
    adv;
    chk("sel_oob", 32'(b_cnt), 32'd0);

    // Non-power-of-2 wrap: ptr=1 -> grants 1,2,0,1
    b_empty_n = 3'b111;
    for (int k = 0; k < 4; k++) begin
      smp;
      chk_b_grant($sformatf("wrap%0d", k), (k + 1) % 3);
      adv;
    end

    // Reset mid-stream: ptr=2 here, outputs drop as soon as RST falls
    smp;
    chk_b_grant("pre_rst", 2);
    b_rst = 1'b0;
    #1;
    chk("mid_rst_enq", 32'(b_enq), 32'd0);
    chk("mid_rst_deq", 32'(b_deq), 32'd0);
    chk("mid_rst_src", 32'(b_src), 32'd0);
    adv;
    b_rst = 1'b1; b_empty_n = 3'b000;
    for (int i = 0; i < 3; i++) begin
      b_sel = 2'(i);
      adv;
      chk($sformatf("post_rst_cnt%0d", i), 32'(b_cnt), 32'd0);
    end
    b_empty_n = 3'b111;
    smp;
    chk_b_grant("post_rst_ptr", 0);
    adv;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/token_rr_merge.md
# token_rr_merge

Round-robin merge of NUM_IN zero-width token streams into one. Each input is the dequeue side of a depth-2 loopy token FIFO (EMPTY_N/DEQ); the output drives the enqueue side of a downstream loopy token FIFO (FULL_N/ENQ). One token moves per cycle, tagged with its source index. Per-source saturating transfer counters are readable for debug and performance monitoring.

## Interface
Parameters:
- NUM_IN, 4, number of input token streams (2..16)
- CNT_WIDTH, 16, width of each per-source transfer counter
- SRC_W, max(1, clog2(NUM_IN)), width of source index

Ports:
- CLK  input  1  clock; all state updates on posedge
- RST  input  1  reset, synchronous, active-low
- IN_EMPTY_N  input  NUM_IN  bit i high: input FIFO i holds a token
- IN_DEQ  output  NUM_IN  bit i high: dequeue input FIFO i this cycle (one-hot or zero)
- OUT_FULL_N  input  1  downstream FIFO can accept a token (may depend combinationally on downstream DEQ)
- OUT_ENQ  output  1  enqueue one token downstream this cycle
- OUT_SRC  output  SRC_W  index of granted input; valid only when OUT_ENQ=1
- CLR  input  1  synchronous clear of pointer and counters
- CNT_SEL  input  SRC_W  counter read select
- CNT_VALUE  output  CNT_WIDTH  registered value of counter CNT_SEL

## Operation
- State: round-robin pointer ptr (SRC_W bits, range 0..NUM_IN-1); NUM_IN counters cnt[i]; CNT_VALUE register.
- Grant g: first i in order ptr, ptr+1, …, wrapping mod NUM_IN, with IN_EMPTY_N[i]=1.
- xfer = RST && !CLR && OUT_FULL_N && |IN_EMPTY_N.
- When xfer=1: IN_DEQ = one-hot(g), OUT_ENQ=1, OUT_SRC=g. Otherwise IN_DEQ=0, OUT_ENQ=0, and OUT_SRC=0.
- On a xfer posedge: ptr ← (g+1) mod NUM_IN; cnt[g] ← cnt[g]+1, saturating at all-ones.
- On a non-xfer posedge: ptr and counters hold.
- On CLR=1 (with RST high): ptr ← 0, all cnt ← 0, no transfer that cycle.
- Reset (RST=0): ptr ← 0, all cnt ← 0, CNT_VALUE ← 0. IN_DEQ and OUT_ENQ are held 0 while RST=0.
- CNT_VALUE ← cnt[CNT_SEL] every cycle, using the pre-update value. If CNT_SEL ≥ NUM_IN, CNT_VALUE ← 0.
- No combinational path from IN_DEQ/OUT_ENQ back to the block's inputs. The path OUT_FULL_N→OUT_ENQ→IN_DEQ is combinational by design.

## Timing
- Zero-cycle latency: a token present on input i with OUT_FULL_N=1 and i granted moves in the same cycle.
- Throughput: 1 token/cycle, sustained while any input is non-empty and downstream is not full.
- Fairness: with all inputs continuously non-empty, the grant sequence is 0,1,…,NUM_IN-1,0,…. Any non-empty input waits at most NUM_IN-1 transfers.
- Pointer wrap: g=NUM_IN-1 sets ptr ← 0. For non-power-of-2 NUM_IN, ptr never exceeds NUM_IN-1.
- Counter read latency: 1 cycle from CNT_SEL to CNT_VALUE.
- Simultaneous CLR and a would-be transfer: CLR wins; no DEQ or ENQ is issued and no count is recorded.
- Reset mid-stream: outputs go to 0 in the same cycle RST falls. State is reset at that posedge.

## Structure
- Shared include holds the clog2 function/macro used for SRC_W and the BSV_ASSIGNMENT_DELAY default.
- Sub-module rr_pick (parameter N): combinational rotate-priority encoder. Inputs: req[N] and ptr. Outputs: any and grant index. Instantiated once.
- Counters and the CNT_VALUE mux live in the top level.
- Simulation-only checks, inside translate_off:
  - IN_DEQ[i]=1 while IN_EMPTY_N[i]=0.
  - OUT_ENQ=1 while OUT_FULL_N=0.
  - IN_DEQ not one-hot-or-zero.

## Test plan
- Reset then idle: RST=0 for 2 cycles, then IN_EMPTY_N=0 → IN_DEQ=0, OUT_ENQ=0, CNT_VALUE=0 for all CNT_SEL.
- All busy, NUM_IN=4: IN_EMPTY_N=4'b1111, OUT_FULL_N=1 for 8 cycles → OUT_SRC=0,1,2,3,0,1,2,3; each cnt=2.
- Sparse with skip: IN_EMPTY_N=4'b1010, ptr=0 → grants 1,3,1,3; cnt[1]=cnt[3]=2, cnt[0]=cnt[2]=0.
- Back-pressure: OUT_FULL_N=0 for 3 cycles with all inputs non-empty → no DEQ/ENQ, ptr unchanged; the next cycle with OUT_FULL_N=1 grants the original ptr.
- CLR collision: CLR=1 while IN_EMPTY_N=4'b0100, OUT_FULL_N=1 → IN_DEQ=0, OUT_ENQ=0; next cycle grant=2, cnt[2]=1.
- Saturation, CNT_WIDTH=2: 5 transfers from input 0 → CNT_VALUE(sel 0)=3. RST=0 mid-stream → outputs 0 immediately and all counters 0 after the edge.
